// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared run-control definitions for the pipeline stall controller.
// State encodings are visible to the debug unit through o_state.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // ID->EX->MEM->WB plus one spare cycle so HALT retires before the stop
  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pipe_perf_counter.sv
// Free-running wrap-around event counter with enable and synchronous clear.
module pipe_perf_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [NB_CNT-1:0] o_count
);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_enable) begin
      o_count <= o_count + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Run-control FSM and per-stage enable/flush/bubble strobes for the 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to build the stall/flush/cycle performance counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int NB_DRAIN     = 3
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_risk_detected,
  input  logic              i_if_flush,
  input  logic              i_halt_decoded,
  input  logic              i_dbg_run,
  input  logic              i_dbg_step,
  input  logic              i_dbg_pause,
  input  logic              i_dbg_clear,
  output logic              o_pipe_enable,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_stall_count,
  output logic [NB_CNT-1:0] o_flush_count,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_e              state;
  logic [NB_DRAIN-1:0] drain_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_dbg_run) begin
            state <= ST_RUN;
          end else if (i_dbg_step) begin
            state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (i_halt_decoded) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (i_dbg_pause) begin
            state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (i_halt_decoded) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_HALTED;
          end else begin
            drain_cnt <= drain_cnt - NB_DRAIN'(1);
          end
        end
        ST_HALTED: begin
          if (i_dbg_clear) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are Mealy so they line up with the hazard unit's outputs in the same cycle
  always_comb begin
    o_pipe_enable  = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        o_pipe_enable  = 1'b1;
        o_pc_write     = ~i_risk_detected & ~i_halt_decoded;
        o_if_id_write  = ~i_risk_detected;
        o_id_ex_bubble = i_risk_detected;
        // a stalled branch is re-resolved next cycle with forwarded operands
        o_if_id_flush  = i_if_flush & ~i_risk_detected;
      end
      ST_DRAIN: begin
        o_pipe_enable  = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_halted = (state == ST_HALTED);
  assign o_state  = state;

`ifdef PIPE_PERF_CNT_EN
  logic counter_clear;
  logic flush_event;

  assign counter_clear = (state == ST_HALTED) && i_dbg_clear;
  // drain NOPs are housekeeping, not branch flushes
  assign flush_event   = o_if_id_flush && ((state == ST_RUN) || (state == ST_STEP));

  pipe_perf_counter #(.NB_CNT(NB_CNT)) u_cycle_counter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (counter_clear),
    .i_enable  (o_pipe_enable),
    .o_count   (o_cycle_count)
  );

  pipe_perf_counter #(.NB_CNT(NB_CNT)) u_stall_counter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (counter_clear),
    .i_enable  (o_id_ex_bubble),
    .o_count   (o_stall_count)
  );

  pipe_perf_counter #(.NB_CNT(NB_CNT)) u_flush_counter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (counter_clear),
    .i_enable  (flush_event),
    .o_count   (o_flush_count)
  );
`else
  assign o_cycle_count = '0;
  assign o_stall_count = '0;
  assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, async reset
// sequence and randomized commands against a behavioural run-control model.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        risk, if_flush, halt, run, step, pause, clear;
  logic        pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [2:0]  state;
  logic [31:0] stall_count, flush_count, cycle_count;
  logic [8:0]  dut_vec;

  pipeline_stall_ctrl dut (
    .i_clock         (clock),
    .i_reset_n       (reset_n),
    .i_risk_detected (risk),
    .i_if_flush      (if_flush),
    .i_halt_decoded  (halt),
    .i_dbg_run       (run),
    .i_dbg_step      (step),
    .i_dbg_pause     (pause),
    .i_dbg_clear     (clear),
    .o_pipe_enable   (pipe_enable),
    .o_pc_write      (pc_write),
    .o_if_id_write   (if_id_write),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_bubble  (id_ex_bubble),
    .o_halted        (halted),
    .o_state         (state),
    .o_stall_count   (stall_count),
    .o_flush_count   (flush_count),
    .o_cycle_count   (cycle_count)
  );

  assign dut_vec = {pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cmd  = {risk, if_flush, halt, run, step, pause, clear}
  // exp  = {pipe_en, pc_write, if_id_write, if_id_flush, bubble, halted, state[2:0]}
  typedef struct {
    logic [6:0] cmd;
    logic [8:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // model: mode 0..4 = idle, run, step, drain, halted; drain_left = enabled drain cycles still owed
  int          m_mode;
  int          m_drain_left;
  logic [31:0] m_cycle, m_stall, m_flush;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] model_out(input int mode, input logic [6:0] c);
    logic [8:0] o;
    logic r, f, h;
    r = c[6];
    f = c[5];
    h = c[4];
    o = {6'b0, 3'(mode)};
    if (mode == 1 || mode == 2) o[8:3] = {1'b1, !r && !h, !r, f && !r, r, 1'b0};
    else if (mode == 3)         o[8:3] = 6'b101100;
    else if (mode == 4)         o[8:3] = 6'b000001;
    return o;
  endfunction

  task automatic model_reset();
    m_mode       = 0;
    m_drain_left = 0;
    m_cycle      = '0;
    m_stall      = '0;
    m_flush      = '0;
  endtask

  task automatic model_step(input logic [6:0] c, input logic [8:0] o);
    if (o[8]) m_cycle++;
    if (o[4]) m_stall++;
    if (o[5] && (m_mode == 1 || m_mode == 2)) m_flush++;
    case (m_mode)
      0: if (c[3]) m_mode = 1; else if (c[2]) m_mode = 2;
      1: if (c[4]) begin m_mode = 3; m_drain_left = 4; end
         else if (c[1]) m_mode = 0;
      2: if (c[4]) begin m_mode = 3; m_drain_left = 4; end
         else m_mode = 0;
      3: begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 4;
      end
      default: if (c[0]) begin
        m_mode  = 0;
        m_cycle = '0;
        m_stall = '0;
        m_flush = '0;
      end
    endcase
  endtask

  task automatic apply_stimulus(input logic [6:0] c);
    {risk, if_flush, halt, run, step, pause, clear} = c;
  endtask

  task automatic check_output(input string tag, input logic [8:0] exp);
    check({tag, "_strobes"}, 64'(dut_vec), 64'(exp));
    check({tag, "_cycle_cnt"}, 64'(cycle_count), PERF ? 64'(m_cycle) : 64'd0);
    check({tag, "_stall_cnt"}, 64'(stall_count), PERF ? 64'(m_stall) : 64'd0);
    check({tag, "_flush_cnt"}, 64'(flush_count), PERF ? 64'(m_flush) : 64'd0);
  endtask

  // Called at a negedge; leaves the bench at the following negedge
  task automatic run_cycle(input logic [6:0] c, input bit use_tbl, input logic [8:0] tbl_exp,
                           input string tag);
    logic [8:0] m;
    apply_stimulus(c);
    #1;
    m = model_out(m_mode, c);
    check_output(tag, use_tbl ? tbl_exp : m);
    @(posedge clock);
    model_step(c, m);
    @(negedge clock);
  endtask

  vec_t tbl[27];

  initial begin
    tbl[0]  = '{7'b0000000, 9'b000000_000};
    tbl[1]  = '{7'b0001000, 9'b000000_000};
    tbl[2]  = '{7'b0000000, 9'b111000_001};
    tbl[3]  = '{7'b1100000, 9'b100010_001};
    tbl[4]  = '{7'b0100000, 9'b111100_001};
    tbl[5]  = '{7'b0010010, 9'b101000_001};
    tbl[6]  = '{7'b0000000, 9'b101100_011};
    tbl[7]  = '{7'b0001000, 9'b101100_011};
    tbl[8]  = '{7'b1110000, 9'b101100_011};
    tbl[9]  = '{7'b0000100, 9'b101100_011};
    tbl[10] = '{7'b0001000, 9'b000001_100};
    tbl[11] = '{7'b0000000, 9'b000001_100};
    tbl[12] = '{7'b0000001, 9'b000001_100};
    tbl[13] = '{7'b0001100, 9'b000000_000};
    tbl[14] = '{7'b0000010, 9'b111000_001};
    tbl[15] = '{7'b0000100, 9'b000000_000};
    tbl[16] = '{7'b0001000, 9'b111000_010};
    tbl[17] = '{7'b0000000, 9'b000000_000};
    tbl[18] = '{7'b0000100, 9'b000000_000};
    tbl[19] = '{7'b0010000, 9'b101000_010};
    tbl[20] = '{7'b0000000, 9'b101100_011};
    tbl[21] = '{7'b0000000, 9'b101100_011};
    tbl[22] = '{7'b0000000, 9'b101100_011};
    tbl[23] = '{7'b0000000, 9'b101100_011};
    tbl[24] = '{7'b0000000, 9'b000001_100};
    tbl[25] = '{7'b0000001, 9'b000001_100};
    tbl[26] = '{7'b0000000, 9'b000000_000};

    reset_n = 1'b0;
    apply_stimulus(7'b0);
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Directed table straight out of reset
    for (int i = 0; i < 27; i++) begin
      run_cycle(tbl[i].cmd, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Async reset in the middle of a drain, away from any clock edge
    run_cycle(7'b0001000, 1'b0, 9'b0, "ar_run");
    run_cycle(7'b0000000, 1'b0, 9'b0, "ar_go");
    run_cycle(7'b0010000, 1'b0, 9'b0, "ar_halt");
    run_cycle(7'b0000000, 1'b0, 9'b0, "ar_drain");
    apply_stimulus(7'b0);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("ar_pipe_enable", 64'(pipe_enable), 64'd0);
    check("ar_state", 64'(state), 64'd0);
    check("ar_if_id_flush", 64'(if_id_flush), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(7'b0000000, 1'b1, 9'b000000_000, $sformatf("ar_idle%0d", i));
    end

    // Randomized commands and hazards against the model
    for (int i = 0; i < 400; i++) begin
      logic [6:0] c;
      c[6] = ($urandom_range(0, 99) < 25);
      c[5] = ($urandom_range(0, 99) < 25);
      c[4] = ($urandom_range(0, 99) < 6);
      c[3] = ($urandom_range(0, 99) < 10);
      c[2] = ($urandom_range(0, 99) < 8);
      c[1] = ($urandom_range(0, 99) < 6);
      c[0] = ($urandom_range(0, 99) < 20);
      run_cycle(c, 1'b0, 9'b0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
